// File: rtl/rrg_pkg.sv
// Shared command codes, sequencer state type and read-command decode for the ramp generator
// control interface.
package rrg_pkg;

  localparam logic [7:0] CMD_IDLE       = 8'd0;
  localparam logic [7:0] CMD_YSET       = 8'd1;
  localparam logic [7:0] CMD_RSET       = 8'd2;
  localparam logic [7:0] CMD_RISET      = 8'd3;
  localparam logic [7:0] CMD_ROSET      = 8'd4;
  localparam logic [7:0] CMD_UPDATE     = 8'd5;
  localparam logic [7:0] CMD_SEL_SW     = 8'd6;
  localparam logic [7:0] CMD_SEL_EXT    = 8'd7;
  localparam logic [7:0] CMD_START      = 8'd8;
  localparam logic [7:0] CMD_STOP       = 8'd9;
  localparam logic [7:0] CMD_RD_YSET    = 8'd11;
  localparam logic [7:0] CMD_RD_RSET    = 8'd12;
  localparam logic [7:0] CMD_RD_RISET   = 8'd13;
  localparam logic [7:0] CMD_RD_ROSET   = 8'd14;
  localparam logic [7:0] CMD_RD_STATUS  = 8'd16;
  localparam logic [7:0] CMD_RD_Y       = 8'd18;
  localparam logic [7:0] CMD_RD_DATASET = 8'd24;
  localparam logic [7:0] CMD_RD_COUNT   = 8'd25;
  localparam logic [7:0] CMD_RD_PARAMS  = 8'd31;

  typedef enum logic [2:0] {
    StIdle,
    StWY,
    StWR,
    StWRi,
    StWRo,
    StWUpd,
    StSw,
    StRd
  } seq_state_t;

  function automatic logic is_read_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_RD_YSET, CMD_RD_RSET, CMD_RD_RISET, CMD_RD_ROSET, CMD_RD_STATUS,
      CMD_RD_Y, CMD_RD_DATASET, CMD_RD_COUNT, CMD_RD_PARAMS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rrg_cmd_seq_if.sv
// Host request streams plus the multiplexed generator control bus of the command sequencer.
interface rrg_cmd_seq_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_dataset;
  logic [63:0] wr_yset;
  logic [63:0] wr_rset;
  logic [63:0] wr_riset;
  logic [63:0] wr_roset;

  logic        sw_valid;
  logic        sw_ready;
  logic        sw_ext;
  logic [7:0]  sw_dataset;

  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_cmd;
  logic [7:0]  rd_dataset;
  logic        rd_data_valid;
  logic [63:0] rd_data;
  logic        rd_err;

  logic [15:0] reg_control;
  logic [15:0] reg_0;
  logic [15:0] reg_1;
  logic [15:0] reg_2;
  logic [15:0] reg_3;
  logic [15:0] outreg_0;
  logic [15:0] outreg_1;
  logic [15:0] outreg_2;
  logic [15:0] outreg_3;
  logic        busy;

  // Host and generator side, as seen by the environment around the sequencer.
  modport master (
    output wr_valid, wr_dataset, wr_yset, wr_rset, wr_riset, wr_roset,
    output sw_valid, sw_ext, sw_dataset,
    output rd_valid, rd_cmd, rd_dataset,
    output outreg_0, outreg_1, outreg_2, outreg_3,
    input  wr_ready, sw_ready, rd_ready, rd_data_valid, rd_data, rd_err,
    input  reg_control, reg_0, reg_1, reg_2, reg_3, busy
  );

  modport slave (
    input  wr_valid, wr_dataset, wr_yset, wr_rset, wr_riset, wr_roset,
    input  sw_valid, sw_ext, sw_dataset,
    input  rd_valid, rd_cmd, rd_dataset,
    input  outreg_0, outreg_1, outreg_2, outreg_3,
    output wr_ready, sw_ready, rd_ready, rd_data_valid, rd_data, rd_err,
    output reg_control, reg_0, reg_1, reg_2, reg_3, busy
  );

endinterface

// File: rtl/rrg_cmd_seq.sv
// Arbitrates switch/write/readback requests and drives them onto the generator control bus as
// hold/gap timed command steps.
module rrg_cmd_seq
  import rrg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input logic         clk,
  input logic         nReset,
  rrg_cmd_seq_if.slave bus
);

  localparam int unsigned MaxCnt = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic [CntW-1:0] HoldLd = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLd  = CntW'(GAP_CYCLES - 1);

  seq_state_t      state_q;
  logic            gap_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      dset_q;
  logic [63:0]     rset_q, riset_q, roset_q;
  logic [15:0]     ctrl_q;
  logic [63:0]     data_q;
  logic [63:0]     rd_data_q;
  logic            rd_data_valid_q;
  logic            rd_err_q;
  logic            idle;

  assign idle = (state_q == StIdle);

  // Ready is gated by reset so nothing handshakes while the block is held in reset.
  assign bus.sw_ready = nReset & idle & bus.sw_valid;
  assign bus.wr_ready = nReset & idle & bus.wr_valid & ~bus.sw_valid;
  assign bus.rd_ready = nReset & idle & bus.rd_valid & ~bus.sw_valid & ~bus.wr_valid;
  assign bus.busy     = ~idle;

  assign bus.reg_control   = ctrl_q;
  assign bus.reg_3         = data_q[63:48];
  assign bus.reg_2         = data_q[47:32];
  assign bus.reg_1         = data_q[31:16];
  assign bus.reg_0         = data_q[15:0];
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_err        = rd_err_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q         <= StIdle;
      gap_q           <= 1'b0;
      cnt_q           <= '0;
      dset_q          <= '0;
      rset_q          <= '0;
      riset_q         <= '0;
      roset_q         <= '0;
      ctrl_q          <= '0;
      data_q          <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      rd_err_q        <= 1'b0;
    end else begin
      rd_data_valid_q <= 1'b0;
      rd_err_q        <= 1'b0;
      case (state_q)
        StIdle: begin
          gap_q <= 1'b0;
          cnt_q <= HoldLd;
          if (bus.sw_ready) begin
            state_q <= StSw;
            ctrl_q  <= bus.sw_ext ? {8'h00, CMD_SEL_EXT} : {bus.sw_dataset, CMD_SEL_SW};
            data_q  <= '0;
          end else if (bus.wr_ready) begin
            state_q <= StWY;
            dset_q  <= bus.wr_dataset;
            rset_q  <= bus.wr_rset;
            riset_q <= bus.wr_riset;
            roset_q <= bus.wr_roset;
            ctrl_q  <= {bus.wr_dataset, CMD_YSET};
            data_q  <= bus.wr_yset;
          end else if (bus.rd_ready) begin
            if (is_read_cmd(bus.rd_cmd)) begin
              state_q <= StRd;
              ctrl_q  <= {bus.rd_dataset, bus.rd_cmd};
              data_q  <= '0;
            end else begin
              // Illegal code: report immediately, generator bus untouched.
              rd_data_valid_q <= 1'b1;
              rd_err_q        <= 1'b1;
            end
          end
        end
        default: begin
          if (!gap_q) begin
            if (cnt_q == '0) begin
              gap_q  <= 1'b1;
              cnt_q  <= GapLd;
              ctrl_q <= {8'h00, CMD_IDLE};
              data_q <= '0;
              if (state_q == StRd) begin
                rd_data_q       <= {bus.outreg_3, bus.outreg_2, bus.outreg_1, bus.outreg_0};
                rd_data_valid_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else if (cnt_q == '0) begin
            gap_q <= 1'b0;
            cnt_q <= HoldLd;
            case (state_q)
              StWY: begin
                state_q <= StWR;
                ctrl_q  <= {dset_q, CMD_RSET};
                data_q  <= rset_q;
              end
              StWR: begin
                state_q <= StWRi;
                ctrl_q  <= {dset_q, CMD_RISET};
                data_q  <= riset_q;
              end
              StWRi: begin
                state_q <= StWRo;
                ctrl_q  <= {dset_q, CMD_ROSET};
                data_q  <= roset_q;
              end
              StWRo: begin
                state_q <= StWUpd;
                ctrl_q  <= {dset_q, CMD_UPDATE};
                data_q  <= '0;
              end
              default: state_q <= StIdle;
            endcase
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rrg_cmd_seq.sv
// Directed bench for rrg_cmd_seq with a small behavioural generator on the control bus.
module tb_rrg_cmd_seq;
  import rrg_pkg::*;

  localparam logic [63:0] Params  = 64'h0002_0001_0000_00A5;
  localparam logic [63:0] Params2 = 64'hCAFE_0004_0002_0031;

  logic clk = 1'b0;
  logic nReset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  rrg_cmd_seq_if bus ();
  rrg_cmd_seq_if bus2 ();

  rrg_cmd_seq dut (.clk(clk), .nReset(nReset), .bus(bus));
  rrg_cmd_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut2 (.clk(clk), .nReset(nReset), .bus(bus2));

  // Generator model: writes go to a shadow set, UPDATE commits it, reads register one cycle later.
  logic [63:0] shadow [4];
  logic [63:0] gmem [256][4];
  wire  [7:0]  g_cmd  = bus.reg_control[7:0];
  wire  [7:0]  g_ds   = bus.reg_control[15:8];
  wire  [7:0]  g_wi   = g_cmd - 8'd1;
  wire  [7:0]  g_ri   = g_cmd - 8'd11;
  wire  [63:0] g_word = {bus.reg_3, bus.reg_2, bus.reg_1, bus.reg_0};

  always @(posedge clk) begin
    if (g_cmd >= CMD_YSET && g_cmd <= CMD_ROSET) shadow[g_wi[1:0]] <= g_word;
    if (g_cmd == CMD_UPDATE) for (int i = 0; i < 4; i++) gmem[g_ds][i] <= shadow[i];
    if (g_cmd >= CMD_RD_YSET && g_cmd <= CMD_RD_ROSET)
      {bus.outreg_3, bus.outreg_2, bus.outreg_1, bus.outreg_0} <= gmem[g_ds][g_ri[1:0]];
    else if (g_cmd == CMD_RD_PARAMS)
      {bus.outreg_3, bus.outreg_2, bus.outreg_1, bus.outreg_0} <= Params;
  end

  always @(posedge clk)
    {bus2.outreg_3, bus2.outreg_2, bus2.outreg_1, bus2.outreg_0} <=
        (bus2.reg_control[7:0] == CMD_RD_PARAMS) ? Params2 : 64'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] ds, input logic [63:0] y, r, ri, ro);
    logic [63:0] w [5];
    w = '{y, r, ri, ro, 64'h0};
    @(posedge clk); #1;
    bus.wr_dataset = ds; bus.wr_yset = y; bus.wr_rset = r; bus.wr_riset = ri; bus.wr_roset = ro;
    bus.wr_valid = 1'b1;
    @(negedge clk);
    check("wr_ready", bus.wr_ready, 1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    bus.wr_yset = '1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if ((c - 1) % 3 < 2) begin
        check($sformatf("wr_ctrl%0d", c), bus.reg_control, {ds, 8'((c - 1) / 3 + 1)});
        check($sformatf("wr_data%0d", c), {bus.reg_3, bus.reg_2, bus.reg_1, bus.reg_0},
              w[(c - 1) / 3]);
      end else begin
        check($sformatf("wr_gap%0d", c), {bus.reg_control, bus.reg_3, bus.reg_0}, 0);
      end
      check($sformatf("wr_busy%0d", c), bus.busy, 1);
    end
    @(negedge clk);
    check("wr_done_busy", bus.busy, 0);
  endtask

  task automatic do_read(input logic [7:0] cmd, ds, input int vc, input logic [63:0] exp_data,
                         input logic exp_err);
    @(posedge clk); #1;
    bus.rd_cmd = cmd; bus.rd_dataset = ds; bus.rd_valid = 1'b1;
    @(negedge clk);
    check("rd_ready", bus.rd_ready, 1);
    @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("rd%0d_vld%0d", cmd, c), bus.rd_data_valid, 64'(c == vc));
      if (c == vc) begin
        check($sformatf("rd%0d_data", cmd), bus.rd_data, exp_data);
        check($sformatf("rd%0d_err", cmd), bus.rd_err, exp_err);
      end
      if (exp_err) check($sformatf("rd_ill_ctrl%0d", c), bus.reg_control, 0);
      else if (c <= 2) check($sformatf("rd%0d_ctrl%0d", cmd, c), bus.reg_control, {ds, cmd});
    end
  endtask

  initial begin
    int sw_at, wr_at, rd_at;
    logic [15:0] ctrl_log [25];
    logic        vld_log [25];
    logic        r_sw, r_wr, r_rd;

    nReset = 1'b0;
    bus.wr_valid = 1'b1; bus.sw_valid = 1'b0; bus.rd_valid = 1'b0; bus.sw_ext = 1'b0;
    bus.wr_dataset = '0; bus.wr_yset = '0; bus.wr_rset = '0; bus.wr_riset = '0; bus.wr_roset = '0;
    bus.sw_dataset = '0; bus.rd_cmd = '0; bus.rd_dataset = '0;
    bus2.wr_valid = 1'b0; bus2.sw_valid = 1'b0; bus2.rd_valid = 1'b0; bus2.sw_ext = 1'b0;
    bus2.wr_dataset = '0; bus2.wr_yset = '0; bus2.wr_rset = '0; bus2.wr_riset = '0;
    bus2.wr_roset = '0; bus2.sw_dataset = '0; bus2.rd_cmd = '0; bus2.rd_dataset = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", bus.reg_control, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd", {bus.rd_data_valid, bus.rd_err}, 0);
    check("rst_rd_data", bus.rd_data, 0);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    nReset = 1'b1;

    do_write(8'd3, 64'h1000_0000_0000_0000, 64'd1, 64'd2, 64'd4);
    do_read(CMD_RD_YSET, 8'd3, 3, 64'h1000_0000_0000_0000, 1'b0);
    do_read(CMD_RD_PARAMS, 8'd0, 3, Params, 1'b0);
    do_read(8'd10, 8'd0, 1, Params, 1'b1);

    // All three requesters at once: switch, then write, then read.
    @(posedge clk); #1;
    bus.sw_valid = 1'b1; bus.sw_ext = 1'b1; bus.sw_dataset = 8'h55;
    bus.wr_valid = 1'b1; bus.wr_dataset = 8'd5; bus.wr_yset = 64'h1; bus.wr_rset = 64'h2;
    bus.wr_riset = 64'h3; bus.wr_roset = 64'h4;
    bus.rd_valid = 1'b1; bus.rd_cmd = CMD_RD_PARAMS; bus.rd_dataset = 8'd0;
    sw_at = -1; wr_at = -1; rd_at = -1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      r_sw = bus.sw_ready; r_wr = bus.wr_ready; r_rd = bus.rd_ready;
      check($sformatf("arb_onehot%0d", c), 64'((32'(r_sw) + 32'(r_wr) + 32'(r_rd)) <= 1), 1);
      if (r_sw) sw_at = c;
      if (r_wr) wr_at = c;
      if (r_rd) rd_at = c;
      ctrl_log[c] = bus.reg_control;
      vld_log[c]  = bus.rd_data_valid;
      @(posedge clk); #1;
      if (r_sw) bus.sw_valid = 1'b0;
      if (r_wr) bus.wr_valid = 1'b0;
      if (r_rd) bus.rd_valid = 1'b0;
    end
    check("arb_sw_at", 64'(sw_at), 0);
    check("arb_wr_at", 64'(wr_at), 4);
    check("arb_rd_at", 64'(rd_at), 20);
    check("arb_sw_ctrl", ctrl_log[1], 16'h0007);
    check("arb_sw_gap", ctrl_log[3], 16'h0000);
    check("arb_wr_ctrl", ctrl_log[5], 16'h0501);
    check("arb_upd_ctrl", ctrl_log[17], 16'h0505);
    check("arb_rd_ctrl", ctrl_log[21], 16'h001F);
    check("arb_rd_vld", {vld_log[22], vld_log[23], vld_log[24]}, 3'b010);

    // Reset in the middle of a write must leave dataset 3 untouched.
    @(posedge clk); #1;
    bus.wr_dataset = 8'd3; bus.wr_yset = 64'hDEAD_BEEF_0000_0000; bus.wr_rset = 64'h9;
    bus.wr_riset = 64'h9; bus.wr_roset = 64'h9; bus.wr_valid = 1'b1;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("pre_rst_ctrl", bus.reg_control, 16'h0303);
    nReset = 1'b0;
    #1;
    check("async_ctrl", bus.reg_control, 0);
    check("async_busy", bus.busy, 0);
    repeat (2) @(posedge clk); #1;
    nReset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("no_upd%0d", c), {bus.reg_control, 15'h0, bus.busy}, 0);
    end
    do_read(CMD_RD_YSET, 8'd3, 3, 64'h1000_0000_0000_0000, 1'b0);
    do_read(CMD_RD_RSET, 8'd3, 3, 64'd1, 1'b0);

    // Stretched timing instance: 4 hold cycles, 2 gap cycles.
    @(posedge clk); #1;
    bus2.wr_dataset = 8'd2; bus2.wr_yset = 64'hA; bus2.wr_rset = 64'hB;
    bus2.wr_riset = 64'hC; bus2.wr_roset = 64'hD; bus2.wr_valid = 1'b1;
    @(negedge clk);
    check("p_wr_ready", bus2.wr_ready, 1);
    @(posedge clk); #1;
    bus2.wr_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if ((c - 1) % 6 < 4)
        check($sformatf("p_ctrl%0d", c), bus2.reg_control, {8'd2, 8'((c - 1) / 6 + 1)});
      else
        check($sformatf("p_gap%0d", c), bus2.reg_control, 0);
    end
    @(negedge clk);
    check("p_done_busy", bus2.busy, 0);
    check("p_ridx_data", bus2.reg_0, 0);

    @(posedge clk); #1;
    bus2.rd_cmd = CMD_RD_PARAMS; bus2.rd_dataset = 8'd0; bus2.rd_valid = 1'b1;
    @(posedge clk); #1;
    bus2.rd_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("p_rd_vld%0d", c), bus2.rd_data_valid, 64'(c == 5));
      if (c == 5) check("p_rd_data", bus2.rd_data, Params2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
